// File: rtl/fb_pkg.sv
// Shared helpers for the feedback combiner: width math, signed saturation
// and the idle value of the post-strobe cycle counter.
package fb_pkg;

  // Counter idle value; each user slices off its own CNT_W low bits.
  localparam logic [63:0] CNT_IDLE_ALL = '1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Treats the low in_w bits of x as a signed value and clamps it to the
  // signed range of out_w bits.
  function automatic logic signed [63:0] sat_value(input logic signed [63:0] x,
                                                    input int in_w,
                                                    input int out_w);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = (x <<< (64 - in_w)) >>> (64 - in_w);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fb_mac_lane.sv
// One channel of the combiner: input register, signed multiply, floor shift.
// Three registered stages from sig/coef to prod_sh.
module fb_mac_lane #(
  parameter int DATA_W = 13,
  parameter int COEF_W = 21,
  parameter int SHIFT  = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic signed [DATA_W-1:0]                sig,
  input  logic signed [COEF_W-1:0]                coef,
  output logic signed [DATA_W+COEF_W-SHIFT-1:0]   prod_sh
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SH_W   = PROD_W - SHIFT;

  logic signed [DATA_W-1:0] sig_q;
  logic signed [COEF_W-1:0] coef_q;
  logic signed [PROD_W-1:0] prod_q;

  // NOTE: registers use <= so every stage samples the previous stage's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q   <= '0;
      coef_q  <= '0;
      prod_q  <= '0;
      prod_sh <= '0;
    end else begin
      sig_q   <= sig;
      coef_q  <= coef;
      prod_q  <= PROD_W'(sig_q) * PROD_W'(coef_q);
      // >>> on a signed value rounds toward minus infinity; the result fits SH_W bits.
      prod_sh <= SH_W'(prod_q >>> SHIFT);
    end
  end

endmodule

// File: rtl/fb_combiner.sv
// Bunch-by-bunch feedback combiner: N_CH gain-weighted channels summed in a
// registered adder tree, saturated to the DAC width and latched per bunch.
module fb_combiner
  import fb_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 13,
  parameter int COEF_W  = 21,
  parameter int SHIFT   = 16,
  parameter int OUT_W   = 13,
  parameter int N_BUNCH = 2,
  parameter int CNT_W   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              store_strb,
  input  logic                              bunch_strb,
  input  logic [N_CH*DATA_W-1:0]            sig_in,
  input  logic [N_CH*COEF_W-1:0]            coef_in,
  input  logic [CNT_W-1:0]                  latch_dly,
  input  logic                              fb_en,
  input  logic                              sat_clr,
  output logic signed [OUT_W-1:0]           fb_sgnl,
  output logic                              fb_valid,
  output logic [clog2(N_BUNCH+1)-1:0]       bunch_idx,
  output logic                              sat_flag
);

  localparam int L     = clog2(N_CH);
  localparam int NP    = 1 << L;
  localparam int SH_W  = DATA_W + COEF_W - SHIFT;
  localparam int SUM_W = SH_W + L;
  localparam int IDX_W = clog2(N_BUNCH + 1);
  localparam logic [CNT_W-1:0] IDLE = CNT_IDLE_ALL[CNT_W-1:0];

  logic signed [SH_W-1:0] lane_q [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    fb_mac_lane #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .SHIFT  (SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .sig     (sig_in[i*DATA_W +: DATA_W]),
      .coef    (coef_in[i*COEF_W +: COEF_W]),
      .prod_sh (lane_q[i])
    );
  end

  // Level l holds NP>>l nodes, one bit wider than level l-1, so no node can overflow.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int W = SH_W + l;
    localparam int N = NP >> l;
    logic signed [W-1:0] node [N];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NP; i++) begin : g_pad
        if (i < N_CH) begin : g_used
          assign node[i] = lane_q[i];
        end else begin : g_zero
          assign node[i] = '0;
        end
      end
    end else begin : g_add
      always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
          if (rst) node[i] <= '0;
          else     node[i] <= W'(g_lvl[l-1].node[2*i]) + W'(g_lvl[l-1].node[2*i+1]);
        end
      end
    end
  end

  logic signed [SUM_W-1:0] sum;
  logic signed [63:0]      sum_ext;
  logic signed [63:0]      sat_sum;
  logic                    sum_sat;
  logic [CNT_W-1:0]        j_q;
  logic                    latch_hit;

  assign sum       = g_lvl[L].node[0];
  assign sum_ext   = 64'(sum);
  assign sat_sum   = sat_value(sum_ext, SUM_W, OUT_W);
  assign sum_sat   = (sat_sum != sum_ext);
  assign latch_hit = store_strb && (j_q == latch_dly) && (latch_dly != IDLE)
                     && (bunch_idx < IDX_W'(N_BUNCH));

  always_ff @(posedge clk) begin
    if (rst) begin
      j_q       <= IDLE;
      bunch_idx <= '0;
      fb_sgnl   <= '0;
      fb_valid  <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      // A strobe on the latch cycle restarts j only after the latch saw the old j.
      if (!store_strb)        j_q <= IDLE;
      else if (bunch_strb)    j_q <= '0;
      else if (j_q != IDLE)   j_q <= j_q + CNT_W'(1);

      if (!store_strb)        bunch_idx <= '0;
      else if (latch_hit)     bunch_idx <= bunch_idx + IDX_W'(1);

      fb_valid <= latch_hit;
      if (latch_hit) fb_sgnl <= fb_en ? OUT_W'(sat_sum) : '0;

      if (latch_hit && fb_en && sum_sat) sat_flag <= 1'b1;
      else if (sat_clr)                  sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_combiner.sv
// Randomised and directed checks of fb_combiner against an arithmetic model,
// with N_CH = 4, 3 and 1 instances sharing the same control inputs.
module tb_fb_combiner;

  localparam int DATA_W = 13;
  localparam int COEF_W = 21;
  localparam int SHIFT  = 16;
  localparam int OUT_W  = 13;
  localparam int CNT_W  = 8;
  localparam int OUT_MAX = 4095;
  localparam int OUT_MIN = -4096;
  localparam int BUDGET  = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic store_strb = 1'b0;
  logic bunch_strb = 1'b0;
  logic fb_en = 1'b1;
  logic sat_clr = 1'b0;
  logic [CNT_W-1:0] latch_dly = 8'd9;
  logic [4*DATA_W-1:0] sig_in = '0;
  logic [4*COEF_W-1:0] coef_in = '0;

  logic signed [OUT_W-1:0] fb4, fb3, fb1;
  logic v4, v3, v1;
  logic [1:0] idx4, idx3, idx1;
  logic sf4, sf3, sf1;

  int errors = 0;
  int checks = 0;
  int sig_m [4];
  int coef_m [4];

  always #5 clk = ~clk;

  fb_combiner #(.N_CH(4)) dut4 (
    .clk(clk), .rst(rst), .store_strb(store_strb), .bunch_strb(bunch_strb),
    .sig_in(sig_in), .coef_in(coef_in), .latch_dly(latch_dly), .fb_en(fb_en),
    .sat_clr(sat_clr), .fb_sgnl(fb4), .fb_valid(v4), .bunch_idx(idx4), .sat_flag(sf4));

  fb_combiner #(.N_CH(3)) dut3 (
    .clk(clk), .rst(rst), .store_strb(store_strb), .bunch_strb(bunch_strb),
    .sig_in(sig_in[3*DATA_W-1:0]), .coef_in(coef_in[3*COEF_W-1:0]), .latch_dly(latch_dly),
    .fb_en(fb_en), .sat_clr(sat_clr), .fb_sgnl(fb3), .fb_valid(v3), .bunch_idx(idx3),
    .sat_flag(sf3));

  fb_combiner #(.N_CH(1)) dut1 (
    .clk(clk), .rst(rst), .store_strb(store_strb), .bunch_strb(bunch_strb),
    .sig_in(sig_in[DATA_W-1:0]), .coef_in(coef_in[COEF_W-1:0]), .latch_dly(latch_dly),
    .fb_en(fb_en), .sat_clr(sat_clr), .fb_sgnl(fb1), .fb_valid(v1), .bunch_idx(idx1),
    .sat_flag(sf1));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      sig_in[i*DATA_W +: DATA_W]  = DATA_W'(sig_m[i]);
      coef_in[i*COEF_W +: COEF_W] = COEF_W'(coef_m[i]);
    end
  endtask

  task automatic set_all(input int s, input int c);
    for (int i = 0; i < 4; i++) begin
      sig_m[i]  = s;
      coef_m[i] = c;
    end
    apply();
  endtask

  // Unclamped sum of floor(sig*coef / 2^SHIFT) over the first n_ch channels.
  function automatic longint model_raw(input int n_ch);
    longint acc, p, d, q;
    acc = 0;
    d = longint'(1) << SHIFT;
    for (int i = 0; i < n_ch; i++) begin
      p = longint'(sig_m[i]) * longint'(coef_m[i]);
      q = p / d;
      if ((p % d != 0) && (p < 0)) q = q - 1;
      acc += q;
    end
    return acc;
  endfunction

  function automatic int model_fb(input int n_ch, input bit en);
    longint s;
    s = model_raw(n_ch);
    if (!en) return 0;
    if (s > OUT_MAX) return OUT_MAX;
    if (s < OUT_MIN) return OUT_MIN;
    return int'(s);
  endfunction

  function automatic bit model_sat(input int n_ch);
    longint s;
    s = model_raw(n_ch);
    return (s > OUT_MAX) || (s < OUT_MIN);
  endfunction

  task automatic open_window();
    store_strb = 1'b0;
    tick(2);
    store_strb = 1'b1;
    tick(1);
  endtask

  // Pulses bunch_strb and returns edges until dut4's fb_valid, or -1 on timeout.
  task automatic bunch_and_wait(output int n);
    bunch_strb = 1'b1;
    tick();
    bunch_strb = 1'b0;
    n = -1;
    for (int k = 1; k <= BUDGET; k++) begin
      tick();
      if (v4) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (fb4 !== '0)  begin errors++; $display("FAIL reset_fb_sgnl: got %0d expected 0", fb4); end
    checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL reset_fb_valid: got %b expected 0", v4); end
    checks++; if (idx4 !== '0) begin errors++; $display("FAIL reset_bunch_idx: got %0d expected 0", idx4); end
    checks++; if (sf4 !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", sf4); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_sum();
    int n;
    fb_en = 1'b1;
    latch_dly = 8'd9;
    set_all(100, 65536);
    open_window();
    tick(6);
    bunch_and_wait(n);
    checks++; if (n != 10) begin errors++; $display("FAIL basic_latency: got %0d edges expected 10", n); end
    checks++; if (fb4 !== 13'sd400) begin errors++; $display("FAIL basic_sum4: got %0d expected 400", fb4); end
    checks++; if (fb3 !== 13'sd300 || v3 !== 1'b1) begin errors++; $display("FAIL basic_sum3: got %0d valid %b expected 300 valid 1", fb3, v3); end
    checks++; if (fb1 !== 13'sd100 || v1 !== 1'b1) begin errors++; $display("FAIL basic_sum1: got %0d valid %b expected 100 valid 1", fb1, v1); end
    checks++; if (sf4 !== 1'b0) begin errors++; $display("FAIL basic_sat_flag: got %b expected 0", sf4); end
    tick(3);
    checks++; if (fb4 !== 13'sd400 || v4 !== 1'b0) begin errors++; $display("FAIL basic_hold: got %0d valid %b expected 400 valid 0", fb4, v4); end
  endtask

  task automatic test_saturation();
    int n;
    set_all(4095, 262144);
    open_window();
    tick(6);
    bunch_and_wait(n);
    checks++; if (fb4 !== 13'sd4095 || sf4 !== 1'b1) begin errors++; $display("FAIL sat_pos: got %0d flag %b expected 4095 flag 1", fb4, sf4); end
    set_all(-4096, 262144);
    tick(6);
    bunch_and_wait(n);
    checks++; if (fb4 !== -13'sd4096 || sf4 !== 1'b1) begin errors++; $display("FAIL sat_neg: got %0d flag %b expected -4096 flag 1", fb4, sf4); end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checks++; if (sf4 !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b expected 0", sf4); end
    // sat_clr held through a saturating latch: the set must win on that edge.
    open_window();
    sat_clr = 1'b1;
    bunch_and_wait(n);
    checks++; if (sf4 !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %b expected 1", sf4); end
    tick();
    sat_clr = 1'b0;
    checks++; if (sf4 !== 1'b0) begin errors++; $display("FAIL sat_clear_after: got %b expected 0", sf4); end
  endtask

  task automatic test_floor_shift();
    int n;
    set_all(0, 0);
    sig_m[0] = -3; coef_m[0] = 32768;
    apply();
    open_window();
    tick(6);
    bunch_and_wait(n);
    checks++; if (fb4 !== -13'sd2) begin errors++; $display("FAIL floor_neg: got %0d expected -2", fb4); end
    sig_m[0] = 3;
    apply();
    tick(6);
    bunch_and_wait(n);
    checks++; if (fb4 !== 13'sd1) begin errors++; $display("FAIL floor_pos: got %0d expected 1", fb4); end
  endtask

  task automatic test_bunch_limit();
    int pulses;
    set_all(100, 65536);
    latch_dly = 8'd9;
    open_window();
    pulses = 0;
    for (int b = 0; b < 3; b++) begin
      bunch_strb = 1'b1;
      tick();
      bunch_strb = 1'b0;
      if (v4) pulses++;
      for (int k = 0; k < 19; k++) begin
        tick();
        if (v4) pulses++;
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL limit_pulses: got %0d expected 2", pulses); end
    checks++; if (idx4 !== 2'd2) begin errors++; $display("FAIL limit_idx: got %0d expected 2", idx4); end
    store_strb = 1'b0;
    tick();
    checks++; if (idx4 !== 2'd0) begin errors++; $display("FAIL limit_idx_clear: got %0d expected 0", idx4); end
  endtask

  task automatic test_back_to_back();
    int n;
    set_all(100, 65536);
    latch_dly = 8'd9;
    open_window();
    bunch_strb = 1'b1;
    tick();
    bunch_strb = 1'b0;
    tick(9);
    bunch_strb = 1'b1;
    tick();
    bunch_strb = 1'b0;
    checks++; if (v4 !== 1'b1 || fb4 !== 13'sd400) begin errors++; $display("FAIL b2b_first: got valid %b value %0d expected valid 1 value 400", v4, fb4); end
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (v4) begin n = k; break; end
    end
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_second_latency: got %0d edges expected 10", n); end
    checks++; if (idx4 !== 2'd2) begin errors++; $display("FAIL b2b_idx: got %0d expected 2", idx4); end
  endtask

  task automatic test_control();
    int n, pulses;
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    fb_en = 1'b0;
    set_all(4095, 262144);
    open_window();
    tick(6);
    bunch_and_wait(n);
    checks++; if (n != 10 || fb4 !== '0) begin errors++; $display("FAIL fben_off: got edges %0d value %0d expected 10 and 0", n, fb4); end
    checks++; if (sf4 !== 1'b0) begin errors++; $display("FAIL fben_off_sat: got %b expected 0", sf4); end
    fb_en = 1'b1;
    set_all(100, 65536);
    open_window();
    tick(6);
    bunch_and_wait(n);
    set_all(50, 65536);
    bunch_strb = 1'b1; tick(); bunch_strb = 1'b0;
    tick(5);
    store_strb = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (v4) pulses++; end
    checks++; if (pulses != 0 || fb4 !== 13'sd400) begin errors++; $display("FAIL store_drop: got pulses %0d value %0d expected 0 and 400", pulses, fb4); end
    latch_dly = 8'd255;
    open_window();
    bunch_strb = 1'b1; tick(); bunch_strb = 1'b0;
    pulses = 0;
    for (int k = 0; k < 300; k++) begin tick(); if (v4) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL idle_dly: got %0d pulses expected 0", pulses); end
    latch_dly = 8'd9;
  endtask

  task automatic test_reset_mid();
    int n, pulses;
    set_all(4095, 262144);
    open_window();
    tick(6);
    bunch_and_wait(n);
    bunch_strb = 1'b1; tick(); bunch_strb = 1'b0;
    tick(5);
    rst = 1'b1;
    tick();
    checks++; if (fb4 !== '0 || fb3 !== '0 || fb1 !== '0) begin errors++; $display("FAIL rst_mid_fb: got %0d %0d %0d expected 0 0 0", fb4, fb3, fb1); end
    checks++; if (idx4 !== '0 || sf4 !== 1'b0 || v4 !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got idx %0d flag %b valid %b expected 0 0 0", idx4, sf4, v4); end
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin tick(); if (v4) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_latch: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_params();
    int n;
    // Data changes in the bunch cycle; the minimum delay must already see it.
    latch_dly = 8'd4;
    set_all(7, 65536);
    open_window();
    tick(6);
    set_all(100, 65536);
    bunch_and_wait(n);
    checks++; if (n != 5) begin errors++; $display("FAIL param_lat5: got %0d edges expected 5", n); end
    checks++; if (fb4 !== 13'sd400 || fb3 !== 13'sd300) begin errors++; $display("FAIL param_n4_n3: got %0d %0d expected 400 300", fb4, fb3); end
    latch_dly = 8'd2;
    set_all(7, 65536);
    open_window();
    tick(6);
    set_all(100, 65536);
    bunch_and_wait(n);
    checks++; if (n != 3 || fb1 !== 13'sd100) begin errors++; $display("FAIL param_n1: got edges %0d value %0d expected 3 and 100", n, fb1); end
    checks++; if (fb4 !== 13'sd28 || fb3 !== 13'sd21) begin errors++; $display("FAIL param_stale: got %0d %0d expected 28 21", fb4, fb3); end
  endtask

  task automatic test_random();
    int n, dly, cr, exp_fb;
    bit en, exp_flag;
    int ranges [3] = '{4096, 65536, 1048575};
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    exp_flag = 1'b0;
    for (int it = 0; it < 12; it++) begin
      en  = ($urandom_range(0, 3) != 0);
      dly = $urandom_range(4, 30);
      cr  = ranges[$urandom_range(0, 2)];
      for (int i = 0; i < 4; i++) begin
        sig_m[i]  = int'($urandom_range(0, 8191)) - 4096;
        coef_m[i] = int'($urandom_range(0, 2 * cr)) - cr;
      end
      apply();
      fb_en = en;
      latch_dly = CNT_W'(dly);
      if (it % 3 == 0) begin
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        exp_flag = 1'b0;
      end
      open_window();
      tick(6);
      bunch_and_wait(n);
      exp_fb = model_fb(4, en);
      if (en && model_sat(4)) exp_flag = 1'b1;
      checks++; if (n != dly + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d edges expected %0d", it, n, dly + 1); end
      checks++; if (fb4 !== OUT_W'(exp_fb)) begin errors++; $display("FAIL rand_value[%0d]: got %0d expected %0d", it, fb4, exp_fb); end
      checks++; if (sf4 !== exp_flag) begin errors++; $display("FAIL rand_sat_flag[%0d]: got %b expected %b", it, sf4, exp_flag); end
    end
    fb_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_saturation();
    test_floor_shift();
    test_bunch_limit();
    test_back_to_back();
    test_control();
    test_reset_mid();
    test_params();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_combiner.md
Name: fb_combiner

Overview:
- Parametrised successor to the fixed 4-channel, 2-bunch feedback summer.
- Multiplies N_CH signed BPM channel samples by per-channel signed gain coefficients, scales, sums through a registered adder tree and saturates to DAC width.
- Latches the result once per bunch, at a programmable cycle offset after the bunch strobe.
- Sits between the channel mux / gain LUT logic and the kicker DAC drive.

Parameters:
- N_CH, 4, number of channels (1..16).
- DATA_W, 13, signed width of each channel sample.
- COEF_W, 21, signed width of each gain coefficient.
- SHIFT, 16, arithmetic right shift applied to each product (coef 2^SHIFT = gain 1.0).
- OUT_W, 13, signed output width.
- N_BUNCH, 2, maximum latches per store window.
- CNT_W, 8, width of the post-strobe cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- store_strb  in  1  store window gate; high = window open.
- bunch_strb  in  1  single-cycle bunch-arrival strobe.
- sig_in  in  N_CH*DATA_W  packed signed samples; channel 0 in the LSBs.
- coef_in  in  N_CH*COEF_W  packed signed gains; channel 0 in the LSBs.
- latch_dly  in  CNT_W  cycles from bunch_strb to latch; treated as static inside a window.
- fb_en  in  1  feedback enable.
- sat_clr  in  1  clears sat_flag.
- fb_sgnl  out  OUT_W  signed feedback output (DAC word).
- fb_valid  out  1  one-cycle pulse on every fb_sgnl update.
- bunch_idx  out  clog2(N_BUNCH+1)  number of latches so far in the current window.
- sat_flag  out  1  sticky saturation indicator.

Behaviour:
- Reset values: fb_sgnl=0, fb_valid=0, bunch_idx=0, sat_flag=0, counter j=IDLE (all ones), all pipeline registers 0.
- Lane pipeline:
  - Cycle 1: register sig/coef.
  - Cycle 2: full-precision product, DATA_W+COEF_W bits, registered.
  - Cycle 3: arithmetic shift right by SHIFT (floor), registered.
- Adder tree:
  - L = clog2(N_CH) registered levels (L=0 when N_CH=1).
  - Each level widens by 1 bit; no overflow inside the tree.
  - Total latency from input to sum register: PIPE_LAT = 3+L.
  - Software sets latch_dly >= PIPE_LAT-1 to sample bunch data.
- Counter j:
  - rst or store_strb=0 -> IDLE.
  - Else bunch_strb -> 0.
  - Else j != IDLE -> j+1; j saturates at IDLE and never wraps.
- Latch condition: store_strb & j==latch_dly & latch_dly!=IDLE & bunch_idx<N_BUNCH. On the next edge:
  - fb_en=1: fb_sgnl = sat(sum); fb_valid=1; bunch_idx+1.
  - fb_en=0: fb_sgnl = 0; fb_valid=1; bunch_idx+1. The kicker is safed but bunch counting continues.
- Saturation:
  - sum > 2^(OUT_W-1)-1 -> max; sum < -2^(OUT_W-1) -> min.
  - Either case sets sat_flag, but only on a latch with fb_en=1.
- sat_clr and a saturating latch in the same cycle -> sat_flag=1 (set wins).
- bunch_strb in the same cycle as a latch: the latch uses the pre-update j; j then restarts at 0.
- bunch_idx == N_BUNCH: further strobes still reset j, but no latch occurs until the window closes.
- store_strb low -> bunch_idx=0 on the next edge. fb_sgnl holds its last value between latches and across windows.
- rst mid-window returns every register to its reset value; the pipeline flushes to zero.

Decomposition:
- Shared package fb_pkg holds:
  - clog2 function.
  - Signed saturate function, parametrised by input and output widths.
  - IDLE counter constant (all ones of CNT_W).
- Sub-module fb_mac_lane: per-channel input register, multiply and shift pipeline, 3-cycle latency. Instantiated N_CH times via generate.
- Adder tree and latch/counter control live in fb_combiner.

Test Plan:
- Basic sum (defaults): all sig=100, coef=65536, latch_dly=9, bunch_strb at cycle T -> fb_sgnl=400 and fb_valid=1 at edge T+10; fb_sgnl holds 400 afterwards; sat_flag=0.
- Saturation: all sig=4095, coef=262144 -> fb_sgnl=4095, sat_flag=1. Then all sig=-4096 -> fb_sgnl=-4096. sat_clr with no saturating latch -> sat_flag=0.
- Floor shift: ch0 sig=-3, coef=32768, other channels 0 -> fb_sgnl=-2. ch0 sig=3 -> fb_sgnl=1.
- Bunch limit: N_BUNCH=2, three bunch_strb 20 cycles apart in one window -> exactly two fb_valid pulses and bunch_idx=2. Drop store_strb -> bunch_idx=0.
- Control edges:
  - fb_en=0 with saturating data -> fb_sgnl=0, fb_valid pulses, sat_flag stays 0.
  - store_strb dropped at j=5 with latch_dly=9 -> no fb_valid, fb_sgnl unchanged.
- Reset and parametrisation: rst asserted at j=5 -> all outputs 0 next edge, no latch at j=9. Repeat the basic sum with N_CH=3 and N_CH=1 -> 300 and 100 respectively, at the PIPE_LAT-adjusted latch_dly.
